// File: rtl/move_sequencer_pkg.sv
// move_sequencer_pkg: board constants, sequencer states and key codes shared with the game core
package move_sequencer_pkg;
    localparam int NUM_COLS = 10;
    localparam int NUM_ROWS = 20;
    localparam int SPAWN_COL = 3;
    localparam int KEY_GAP = 2;
    localparam logic [3:0] KEY_NONE = 4'b0000;
    localparam logic [3:0] KEY_ROTATE = 4'b0001;
    localparam logic [3:0] KEY_LEFT = 4'b0010;
    localparam logic [3:0] KEY_RIGHT = 4'b0100;
    localparam logic [3:0] KEY_DROP = 4'b1000;
    typedef enum logic [2:0] {IDLE, ROTATE, SHIFT, DROP, GAP, FINISH} state_t;
    function automatic state_t first_phase(input logic has_rot, input logic has_shift);
        return has_rot ? ROTATE : has_shift ? SHIFT : DROP;
    endfunction
    function automatic logic [3:0] key_code(input state_t s, input logic right);
        return s == ROTATE ? KEY_ROTATE : s == SHIFT ? (right ? KEY_RIGHT : KEY_LEFT) : s == DROP ? KEY_DROP : KEY_NONE;
    endfunction
endpackage

// File: rtl/move_sequencer_gap.sv
// gap_timer: loadable down-counter that reports expired while it sits at zero
module gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;
    // load wins; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign expired_o = cnt_q == '0;
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: replays a placement as rotate/shift/drop key pulses; MOVE_SEQ_ACK_EN holds each key until key_ack
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int NUM_COLS = move_sequencer_pkg::NUM_COLS,
    parameter int SPAWN_COL = move_sequencer_pkg::SPAWN_COL,
    parameter int KEY_GAP = move_sequencer_pkg::KEY_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] tgt_col,
    input  logic [1:0] tgt_rot,
    output logic       key_rotate,
    output logic       key_left,
    output logic       key_right,
    output logic       key_drop,
    input  logic       key_ack,
    output logic       busy,
    output logic       done
);
    localparam int SW = NUM_COLS > 2 ? $clog2(NUM_COLS) : 1;
    localparam int GW = KEY_GAP > 2 ? $clog2(KEY_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(KEY_GAP > 0 ? KEY_GAP - 1 : 0);
    localparam logic [3:0] MAX_COL = 4'(NUM_COLS - 1);
    localparam logic [3:0] SPAWN = 4'(SPAWN_COL);
    state_t state_q, start_state, nxt_state;
    logic [1:0] rot_q, rot_d;
    logic [SW-1:0] shift_q, shift_d, shift_in;
    logic [3:0] keys_q, col_t;
    logic dir_q, dropped_q, busy_q, done_q, go_right, in_phase, step, fire, gap_expired;
`ifdef MOVE_SEQ_ACK_EN
    assign step = key_ack;
`else
    logic unused_ack;
    assign unused_ack = key_ack;
    assign step = 1'b1;
`endif
    // target decode, counter decrement and next-phase selection
    always_comb begin
        col_t = tgt_col > MAX_COL ? MAX_COL : tgt_col;
        go_right = col_t > SPAWN;
        shift_in = SW'(go_right ? col_t - SPAWN : SPAWN - col_t);
        start_state = first_phase(tgt_rot != 2'd0, shift_in != '0);
        in_phase = state_q == ROTATE || state_q == SHIFT || state_q == DROP;
        fire = in_phase && step;
        rot_d = (state_q == ROTATE && fire) ? rot_q - 2'd1 : rot_q;
        shift_d = (state_q == SHIFT && fire) ? shift_q - 1'b1 : shift_q;
        nxt_state = (state_q == DROP || dropped_q) ? FINISH : first_phase(rot_d != 2'd0, shift_d != '0);
    end
    gap_timer #(.W(GW)) u_gap (
        .clk(clk),
        .rst(rst),
        .load_i(fire),
        .val_i(GAP_LOAD),
        .expired_o(gap_expired)
    );
    // sequencer FSM with registered key, busy and done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rot_q <= 2'd0;
            shift_q <= '0;
            dir_q <= 1'b0;
            dropped_q <= 1'b0;
            keys_q <= KEY_NONE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= start_state;
                    keys_q <= key_code(start_state, go_right);
                    rot_q <= tgt_rot;
                    shift_q <= shift_in;
                    dir_q <= go_right;
                    dropped_q <= 1'b0;
                    busy_q <= 1'b1;
                end
                ROTATE, SHIFT, DROP: if (fire) begin
                    rot_q <= rot_d;
                    shift_q <= shift_d;
                    dropped_q <= dropped_q || state_q == DROP;
                    state_q <= KEY_GAP > 0 ? GAP : nxt_state;
                    keys_q <= KEY_GAP > 0 ? KEY_NONE : key_code(nxt_state, dir_q);
                    busy_q <= KEY_GAP > 0 || nxt_state != FINISH;
                    done_q <= KEY_GAP == 0 && nxt_state == FINISH;
                end
                GAP: if (gap_expired) begin
                    state_q <= nxt_state;
                    keys_q <= key_code(nxt_state, dir_q);
                    busy_q <= nxt_state != FINISH;
                    done_q <= nxt_state == FINISH;
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign {key_drop, key_right, key_left, key_rotate} = keys_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed pulse-train checks for move_sequencer at KEY_GAP=2, SPAWN_COL=3
module tb_move_sequencer;
    logic clk = 1'b0;
    logic rst, start, key_ack;
    logic [3:0] tgt_col;
    logic [1:0] tgt_rot;
    logic key_rotate, key_left, key_right, key_drop, busy, done;
    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] tr [6];
    logic [63:0] ex [6];
    logic excl;
    string nm [6] = '{"rotate", "left", "right", "drop", "done", "busy"};

    move_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .tgt_col(tgt_col), .tgt_rot(tgt_rot),
        .key_rotate(key_rotate), .key_left(key_left), .key_right(key_right), .key_drop(key_drop),
        .key_ack(key_ack), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int lo, input int hi, input int st);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i += st) m[i] = 1'b1;
        return m;
    endfunction

    task automatic go(input logic [3:0] col, input logic [1:0] rot);
        start = 1'b1;
        tgt_col = col;
        tgt_rot = rot;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic capture(input int n, input int inj_at, input bit ack_mode);
        int hcnt = 0;
        for (int i = 0; i < 6; i++) tr[i] = '0;
        excl = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tr[0][k] = key_rotate;
            tr[1][k] = key_left;
            tr[2][k] = key_right;
            tr[3][k] = key_drop;
            tr[4][k] = done;
            tr[5][k] = busy;
            if ($countones({key_rotate, key_left, key_right, key_drop}) > 1) excl = 1'b1;
            if (ack_mode) begin
                hcnt = (key_rotate | key_left | key_right | key_drop) ? hcnt + 1 : 0;
                key_ack = hcnt == 5;
            end
            if (k == inj_at) begin
                start = 1'b1;
                tgt_col = 4'd0;
                tgt_rot = 2'd3;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        key_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        key_ack = 1'b0;
        tgt_col = 4'd0;
        tgt_rot = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({key_rotate, key_left, key_right, key_drop, busy, done} !== 6'b0)
            $display("FAIL reset_outputs: got %b expected 000000", {key_rotate, key_left, key_right, key_drop, busy, done});
        else n_pass++;
        rst = 1'b0;
        capture(4, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== 64'd0) $display("FAIL idle_%s: got %h expected 0", nm[i], tr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rot1_right2;
        go(4'd5, 2'd1);
        capture(16, 0, 1'b0);
        ex = '{rng(1, 1, 1), 64'd0, rng(4, 7, 3), rng(10, 10, 1), rng(13, 13, 1), rng(1, 12, 1)};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== ex[i]) $display("FAIL rot1_right2_%s: got %h expected %h", nm[i], tr[i], ex[i]);
            else n_pass++;
        end
        n_checks++;
        if (excl !== 1'b0) $display("FAIL rot1_right2_exclusive: got %b expected 0", excl);
        else n_pass++;
    endtask

    task automatic test_drop_only;
        go(4'd3, 2'd0);
        capture(8, 0, 1'b0);
        ex = '{64'd0, 64'd0, 64'd0, rng(1, 1, 1), rng(4, 4, 1), rng(1, 3, 1)};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== ex[i]) $display("FAIL drop_only_%s: got %h expected %h", nm[i], tr[i], ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rot3_left3;
        go(4'd0, 2'd3);
        capture(25, 0, 1'b0);
        ex = '{rng(1, 7, 3), rng(10, 16, 3), 64'd0, rng(19, 19, 1), rng(22, 22, 1), rng(1, 21, 1)};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== ex[i]) $display("FAIL rot3_left3_%s: got %h expected %h", nm[i], tr[i], ex[i]);
            else n_pass++;
        end
        n_checks++;
        if (excl !== 1'b0) $display("FAIL rot3_left3_exclusive: got %b expected 0", excl);
        else n_pass++;
    endtask

    task automatic test_clamp;
        go(4'd15, 2'd0);
        capture(25, 0, 1'b0);
        ex = '{64'd0, 64'd0, rng(1, 16, 3), rng(19, 19, 1), rng(22, 22, 1), rng(1, 21, 1)};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== ex[i]) $display("FAIL clamp_%s: got %h expected %h", nm[i], tr[i], ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        go(4'd5, 2'd1);
        capture(16, 5, 1'b0);
        ex = '{rng(1, 1, 1), 64'd0, rng(4, 7, 3), rng(10, 10, 1), rng(13, 13, 1), rng(1, 12, 1)};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== ex[i]) $display("FAIL busy_start_%s: got %h expected %h", nm[i], tr[i], ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort;
        go(4'd5, 2'd1);
        capture(5, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({key_rotate, key_left, key_right, key_drop, busy, done} !== 6'b0)
            $display("FAIL async_abort: got %b expected 000000", {key_rotate, key_left, key_right, key_drop, busy, done});
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        capture(12, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== 64'd0) $display("FAIL post_abort_%s: got %h expected 0", nm[i], tr[i]);
            else n_pass++;
        end
        go(4'd2, 2'd0);
        capture(8, 0, 1'b0);
        ex = '{64'd0, rng(1, 1, 1), 64'd0, rng(4, 4, 1), rng(7, 7, 1), rng(1, 6, 1)};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== ex[i]) $display("FAIL restart_%s: got %h expected %h", nm[i], tr[i], ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ack;
`ifdef MOVE_SEQ_ACK_EN
        go(4'd4, 2'd0);
        capture(18, 0, 1'b1);
        ex = '{64'd0, 64'd0, rng(1, 5, 1), rng(8, 12, 1), rng(15, 15, 1), rng(1, 14, 1)};
`else
        key_ack = 1'b1;
        go(4'd4, 2'd0);
        capture(10, 0, 1'b0);
        ex = '{64'd0, 64'd0, rng(1, 1, 1), rng(4, 4, 1), rng(7, 7, 1), rng(1, 6, 1)};
`endif
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr[i] !== ex[i]) $display("FAIL ack_%s: got %h expected %h", nm[i], tr[i], ex[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_rot1_right2;
        test_drop_only;
        test_rot3_left3;
        test_clamp;
        test_back_to_back;
        test_reset_abort;
        test_ack;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
